// File: rtl/axi_arb_wrr.sv
// Weighted round-robin / fixed-priority arbiter for an AXI request handshake.
// The grant is held stable while out_req_o is waiting for out_ack_i.
module axi_arb_wrr #(
  parameter  int NUM_REQ    = 4,
  parameter  int WEIGHT     = 1,
  parameter  int FIXED_PRIO = 0,
  localparam int SEL_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] in_req_i,
  output logic [NUM_REQ-1:0] in_ack_o,
  output logic               out_req_o,
  input  logic               out_ack_i,
  output logic [SEL_W-1:0]   out_sel_o
);
  localparam int CNT_W = $clog2(WEIGHT) + 1;

  logic [SEL_W-1:0] ptr, ptr_n, lock_idx, lock_idx_n, win;
  logic [CNT_W-1:0] cnt, cnt_n, c;
  logic             lock, lock_n, lock_req, hs;

  // Winner = requesting index at the smallest rotated distance from ptr.
  always_comb begin
    int best, d;
    win  = '0;
    best = NUM_REQ;
    d    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (FIXED_PRIO != 0)      d = i;
      else if (i >= int'(ptr))  d = i - int'(ptr);
      else                      d = i + NUM_REQ - int'(ptr);
      if (in_req_i[i] && d < best) begin
        best = d;
        win  = SEL_W'(i);
      end
    end
  end

  always_comb begin
    lock_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (lock_idx == SEL_W'(i)) lock_req = in_req_i[i];
  end

  always_comb begin
    out_sel_o = '0;
    if (NUM_REQ > 1) out_sel_o = lock ? lock_idx : win;
    out_req_o = lock ? lock_req : |in_req_i;
  end

  assign hs = out_req_o & out_ack_i;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ack
    assign in_ack_o[i] = hs & (out_sel_o == SEL_W'(i));
  end

  // A dropped request while locked simply unlocks: out_req_o is low, so no handshake.
  always_comb begin
    lock_n     = out_req_o & ~out_ack_i;
    lock_idx_n = lock_n ? out_sel_o : lock_idx;
    ptr_n      = ptr;
    cnt_n      = cnt;
    c          = (out_sel_o == ptr) ? cnt : '0;
    if (hs && FIXED_PRIO == 0) begin
      if (int'(c) + 1 < WEIGHT) begin
        ptr_n = out_sel_o;
        cnt_n = c + CNT_W'(1);
      end else begin
        ptr_n = (out_sel_o == SEL_W'(NUM_REQ - 1)) ? '0 : out_sel_o + SEL_W'(1);
        cnt_n = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr      <= '0;
      cnt      <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else begin
      ptr      <= ptr_n;
      cnt      <= cnt_n;
      lock     <= lock_n;
      lock_idx <= lock_idx_n;
    end
  end
endmodule

// File: doc/axi_arb_wrr.md
Name: axi_arb_wrr

Overview:
- Parametrised weighted round-robin arbiter that drives the requestor/arbiter handshake of the AXI arbitration interface: in_req/in_ack on the requestor side, out_req/out_ack/out_sel on the arbiter side.
- Generalises plain arbitration with three additions:
  - selectable fixed-priority or weighted round-robin mode;
  - a per-requestor burst weight (consecutive grants);
  - AXI-style grant locking, so out_sel never changes while out_req is pending.
- Sits in front of AXI/AXI-Lite muxes to pick which master's AW/AR channel is forwarded.

Parameters:
- NUM_REQ, 4, number of requestors (>=1, need not be a power of two).
- WEIGHT, 1, max consecutive handshakes granted to one requestor before the pointer rotates (>=1).
- FIXED_PRIO, 0, 1 = lowest index always wins; pointer and weight are ignored.
- SEL_W, max(1,$clog2(NUM_REQ)), width of out_sel_o (derived localparam).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- in_req_i  in  NUM_REQ  per-requestor request; must stay high until acked
- in_ack_o  out  NUM_REQ  one-hot ack, in_ack_o[i] = out_ack_i & out_req_o & (out_sel_o==i)
- out_req_o  out  1  arbitrated request towards the downstream
- out_ack_i  in  1  downstream accept; a handshake is out_req_o & out_ack_i
- out_sel_o  out  SEL_W  index of the granted requestor

Behaviour:
- One clock clk_i; reset rst_i is asynchronous and active-high.
- State registers and their reset values:
  - ptr = 0 (SEL_W bits)
  - cnt = 0 ($clog2(WEIGHT)+1 bits)
  - lock = 0
  - lock_idx = 0
- Outputs are combinational from state and inputs, so request-to-grant latency is 0 cycles.
- Outputs during/after reset with in_req_i = 0: out_req_o = 0, out_sel_o = 0, in_ack_o = 0.
- Unlocked winner:
  - RR mode: the first i with in_req_i[i]=1, scanning ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
  - FIXED mode: the lowest set index.
  - out_req_o = |in_req_i.
  - out_sel_o = winner; 0 when there is no request.
- Locked state (lock=1):
  - out_sel_o = lock_idx; out_req_o = in_req_i[lock_idx].
  - Other requests are ignored, including newly arriving higher-priority ones.
- Lock transitions, per cycle:
  - out_req_o & ~out_ack_i → lock <= 1, lock_idx <= out_sel_o.
  - Handshake → lock <= 0.
  - Locked and in_req_i[lock_idx] = 0 (protocol violation) → lock <= 0, no ack, ptr/cnt unchanged.
- Pointer update on a handshake with index j, RR mode only:
  - c = (j==ptr) ? cnt : 0.
  - If c+1 < WEIGHT: ptr <= j, cnt <= c+1.
  - Else: ptr <= (j==NUM_REQ-1) ? 0 : j+1, cnt <= 0.
  - Wrap is explicit; there is no modulo on a power-of-two width.
- No handshake → ptr and cnt hold. FIXED mode → ptr and cnt stay 0.
- NUM_REQ = 1: out_sel_o is tied 0; out_req_o = in_req_i[0].
- Simultaneous handshake and a new request on the same cycle: the new winner is computed from the updated ptr on the following cycle; there is no combinational use of next-state.
- Reset asserted mid-lock: all state clears immediately; the first cycle after release arbitrates from ptr = 0.

Test Plan:
- Reset: rst_i=1, in_req_i=4'b1111 → out_sel_o=0, out_req_o=1, no state change; release with out_ack_i=0 → lock asserted, sel stays 0.
- RR, WEIGHT=1, in_req_i=4'b1111, out_ack_i=1 constant → out_sel_o sequence 0,1,2,3,0,1; exactly one in_ack_o bit per cycle.
- WEIGHT=2, same stimulus → out_sel_o sequence 0,0,1,1,2,2,3,3,0.
- Lock: in_req_i=4'b0100, out_ack_i=0 for 3 cycles; then in_req_i=4'b0101 → out_sel_o stays 2; ack in cycle 5 → in_ack_o=4'b0100; next cycle (WEIGHT=1) out_sel_o=0.
- Wrap, NUM_REQ=3, WEIGHT=1: in_req_i=3'b101, ack constant → sel 0,2,0,2; ptr never reaches 3.
- FIXED_PRIO=1, in_req_i=4'b1010, ack constant → out_sel_o=1 every cycle; requestor 3 never acked.
- Violation: locked at idx 3, drop in_req_i[3] → out_req_o=0 that cycle, lock=0 next cycle, ptr unchanged.
- Async reset mid-lock at idx 3 with in_req_i=4'b1001 → immediately out_sel_o=0, lock=0.
